// File: rtl/alu_pkg.sv
// Shared types and constants for the multicycle ALU.
package alu_pkg;

  // ALUControl encodings
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_EOR = 3'b100,
    OP_ADC = 3'b101,
    OP_SBC = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // Bit positions inside the {N,Z,C,V} flag register
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Ops whose C and V flags come from the adder
  function automatic logic is_arith(alu_op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational N-bit adder/subtractor with carry-in, carry-out and signed overflow.
module alu_addsub #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [N-1:0] b_eff;

  // Subtraction adds the inverted operand; the caller supplies the +1 via cin.
  always_comb begin
    b_eff       = sub ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, cin};
    ovf         = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU: single-cycle ADD/SUB/logic/ADC/SBC, N-cycle shift-add MUL,
// start/ready/done handshake and an NZCV flag register.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   ALUControl,
  input  logic         CarryIn,
  input  logic         SetFlags,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] Result,
  output logic [3:0]   ALUFlags
);

  localparam int unsigned CW = $clog2(N);

  alu_state_t   state_q, state_d;
  logic [N-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;
  logic [N-1:0] mcand_q, mcand_d;
  logic [N-1:0] mplier_q, mplier_d;
  logic [N-1:0] acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic         setflags_q, setflags_d;

  alu_op_t      op;
  logic         accept;
  logic         as_sub;
  logic         as_cin;
  logic [N-1:0] as_sum;
  logic         as_cout;
  logic         as_ovf;
  logic [N-1:0] op_res;
  logic [N-1:0] mul_sum;

  alu_addsub #(.N(N)) u_addsub (
    .a    (a),
    .b    (b),
    .sub  (as_sub),
    .cin  (as_cin),
    .sum  (as_sum),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  assign ready    = (state_q != MUL);
  assign done     = (state_q == DONE);
  assign Result   = result_q;
  assign ALUFlags = flags_q;

  // Decode the incoming op and form its single-cycle result
  always_comb begin
    op     = alu_op_t'(ALUControl);
    accept = start && ready;
    as_sub = (op == OP_SUB) || (op == OP_SBC);
    case (op)
      OP_SUB:         as_cin = 1'b1;
      OP_ADC, OP_SBC: as_cin = CarryIn;
      default:        as_cin = 1'b0;
    endcase
    case (op)
      OP_AND:  op_res = a & b;
      OP_OR:   op_res = a | b;
      OP_EOR:  op_res = a ^ b;
      default: op_res = as_sum;
    endcase
  end

  // Sequencer: accept ops, iterate the multiplier, load result and flags
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    flags_d    = flags_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    count_d    = count_q;
    setflags_d = setflags_q;
    mul_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      MUL: begin
        // The last partial product is folded into the final write rather
        // than taking an extra cycle, giving exactly N cycles of latency.
        if (count_q == '0) begin
          result_d = mul_sum;
          if (setflags_q) begin
            flags_d[FLAG_N] = mul_sum[N-1];
            flags_d[FLAG_Z] = (mul_sum == '0);
          end
          state_d = DONE;
        end else begin
          acc_d    = mul_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          if (op == OP_MUL) begin
            mcand_d    = a;
            mplier_d   = b;
            acc_d      = '0;
            count_d    = CW'(N - 1);
            setflags_d = SetFlags;
            state_d    = MUL;
          end else begin
            result_d = op_res;
            if (SetFlags) begin
              flags_d[FLAG_N] = op_res[N-1];
              flags_d[FLAG_Z] = (op_res == '0);
              if (is_arith(op)) begin
                flags_d[FLAG_C] = as_cout;
                flags_d[FLAG_V] = as_ovf;
              end
            end
            state_d = DONE;
          end
        end
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      result_q   <= '0;
      flags_q    <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      setflags_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      setflags_q <= setflags_d;
    end
  end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- N-bit registered ALU for the multicycle processor datapath.
- Executes ADD/SUB/AND/OR/EOR/ADC/SBC in one cycle and MUL (low N bits) iteratively in N cycles.
- Uses a start/ready/done handshake.
- Holds an NZCV flag register updated only when SetFlags is set, feeding the condition-check unit.

Parameters:
- N, 32: operand/result width, N >= 2.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; accepted on an edge where start=1 and ready=1
- a  in  N  operand A, sampled at acceptance
- b  in  N  operand B, sampled at acceptance
- ALUControl  in  3  op code, sampled at acceptance
- CarryIn  in  1  C input for ADC/SBC, sampled at acceptance
- SetFlags  in  1  update ALUFlags at completion, sampled at acceptance
- ready  out  1  can accept a new op
- done  out  1  one-cycle pulse: Result and ALUFlags are valid this cycle
- Result  out  N  registered result; held until next completion
- ALUFlags  out  4  registered {N,Z,C,V} (bit3..bit0)

Behaviour:
- Reset (sync, dominant over everything):
  - state=IDLE, Result=0, ALUFlags=0, done=0, ready=1.
  - An in-flight MUL is abandoned with no done pulse.
- Op codes:
  - 000 ADD a+b; 001 SUB a+~b+1; 010 AND; 011 OR; 100 EOR.
  - 101 ADC a+b+CarryIn; 110 SBC a+~b+CarryIn; 111 MUL (a*b)[N-1:0].
- Flags, when SetFlags=1:
  - N=Result[N-1]; Z=(Result==0).
  - Arithmetic ops (000,001,101,110): C=carry out of bit N-1 (SUB/SBC: C=1 means no borrow); V=signed overflow, i.e. a[N-1]==b'[N-1] and Result[N-1]!=a[N-1], with b'=b for add and ~b for subtract.
  - Logical ops and MUL: N,Z update; C,V keep their previous values.
  - SetFlags=0: ALUFlags unchanged; Result still updates.
- FSM states: IDLE, MUL, DONE. ready = (state != MUL).
- Single-cycle op accepted at edge k:
  - Result/flags loaded at edge k; state=DONE; done=1 during cycle k..k+1.
  - Next edge: DONE->IDLE, or DONE->DONE/MUL if a new op is accepted. Throughput is 1 op/cycle.
- MUL accepted at edge k:
  - Load mcand=a, mplier=b, acc=0, count=N-1; state=MUL.
  - Each edge in MUL: if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1; count--.
  - Edge where count==0: Result = acc + (mplier[0] ? mcand : 0); flags per rules; state=DONE.
  - done is high in the cycle after edge k+N, so latency is N cycles.
- start while ready=0: ignored, not queued; the requester must hold start.
- All arithmetic is mod 2^N; MUL keeps only the low N bits; operands are treated as unsigned for MUL.
- done is never high for two consecutive cycles from one op. Consecutive done pulses only occur for consecutively accepted ops.
- Result/ALUFlags change only at completion edges or reset.

Decomposition:
- Package alu_pkg holds:
  - enum alu_op_t (3 bits, values above)
  - enum alu_state_t {IDLE, MUL, DONE}
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- Sub-module alu_addsub #(N):
  - inputs a, b, sub, cin
  - outputs sum[N-1:0], cout, ovf
  - purely combinational; reused for ADD/SUB/ADC/SBC.
- The MUL accumulator addition is shared through it or coded inline.

Test Plan:
- reset; ADD 0x7FFFFFFF+0x00000001, SetFlags=1 -> Result=0x80000000, ALUFlags=1001, done one cycle after accept.
- SUB 0x00000005-0x00000005, SetFlags=1 -> Result=0x00000000, ALUFlags=0110; then SBC 0x00000000-0x00000000, CarryIn=0 -> Result=0xFFFFFFFF, ALUFlags=1000.
- ADC 0xFFFFFFFF+0x00000000, CarryIn=1 -> Result=0, ALUFlags=0110.
- With flags=0110, MUL 0x0000FFFF*0x00010001, SetFlags=1 -> Result=0xFFFFFFFF and ALUFlags=1010 (C kept), done exactly 32 cycles after accept. ready=0 throughout; a start pulse at cycle 5 is ignored.
- MUL accepted, reset asserted at cycle 10 -> next cycle Result=0, ALUFlags=0000, ready=1; no done pulse follows.
- Flags=0110; ADD then AND (SetFlags=0) on consecutive cycles -> done on two consecutive cycles; second Result=a&b; ALUFlags reflect the ADD only.
